vector_instr_queue: RTL

- Elastic FIFO between the scalar core's vector-issue port and the vector dispatch stage.
- Buffers scalar-side packets (instruction plus scalar operands) and presents the head entry to dispatch with a valid/pop handshake.
- Its valid_fifo/instruction_out pair drives the dispatch SEW register and the decoders directly.
- Flags when any queued entry is a vector-config instruction, so the scalar side can throttle.

---
 rtl/vector_dispatch_pkg.sv | 15 +
 rtl/vector_instr_queue_if.sv | 33 +++
 rtl/vector_queue_ptr.sv | 20 ++
 rtl/vector_instr_queue.sv | 106 ++++++++++
 4 files changed

// File: rtl/vector_dispatch_pkg.sv
// Shared constants and the vector-config decode used by the instruction queue and the dispatch SEW register.
package vector_dispatch_pkg;

  localparam int DEF_DATA_FROM_SCALAR = 96;
  localparam int DEF_INSTRUCTION_BITS = 32;

  localparam logic [6:0] OPCODE_V     = 7'b1010111;
  localparam logic [2:0] FUNCT3_OPCFG = 3'b111;

  // vsetvli / vsetivli / vsetvl all live in OP-V with funct3 = 111.
  function automatic logic is_vcfg(input logic [DEF_INSTRUCTION_BITS-1:0] instr);
    return (instr[6:0] == OPCODE_V) && (instr[14:12] == FUNCT3_OPCFG);
  endfunction

endpackage

// File: rtl/vector_instr_queue_if.sv
// Scalar-issue / vector-dispatch port bundle of the vector instruction queue.
interface vector_instr_queue_if
  import vector_dispatch_pkg::*;
#(
  parameter int DATA_FROM_SCALAR = DEF_DATA_FROM_SCALAR,
  parameter int DEPTH            = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a push transfers on a cycle where push && ready && !flush; a pop
  // transfers where pop && valid_fifo && !flush. ready and (in the default build)
  // valid_fifo depend only on registered queue state; flush wins over both.
  logic                        push;
  logic [DATA_FROM_SCALAR-1:0] instruction_in;
  logic                        ready;
  logic                        flush;
  logic                        pop;
  logic                        valid_fifo;
  logic [DATA_FROM_SCALAR-1:0] instruction_out;
  logic [CW-1:0]               count;
  logic                        cfg_pending;

  modport master (
    output push, instruction_in, flush, pop,
    input  ready, valid_fifo, instruction_out, count, cfg_pending
  );

  modport slave (
    input  push, instruction_in, flush, pop,
    output ready, valid_fifo, instruction_out, count, cfg_pending
  );

endinterface

// File: rtl/vector_queue_ptr.sv
// Wrapping FIFO pointer: synchronous active-low reset, clear, and increment modulo 2**W.
module vector_queue_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/vector_instr_queue.sv
// Elastic FIFO from the scalar vector-issue port to vector dispatch, with a vector-config pending flag.
// Optional same-cycle empty-queue bypass is enabled by defining VIQ_BYPASS_EN.
module vector_instr_queue
  import vector_dispatch_pkg::*;
#(
  parameter int DATA_FROM_SCALAR = DEF_DATA_FROM_SCALAR,
  parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
  parameter int DEPTH            = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_instr_queue_if.slave  q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
  logic [DEPTH-1:0]            flag;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               cnt;

  logic                        full;
  logic                        empty;
  logic                        valid;
  logic                        push_acc;
  logic                        pop_acc;
  logic                        wr_en;
  logic                        rd_en;
  logic                        in_cfg;
  logic [INSTRUCTION_BITS-1:0] in_instr;

  assign in_instr = q.instruction_in[DATA_FROM_SCALAR-INSTRUCTION_BITS +: INSTRUCTION_BITS];
  assign in_cfg   = is_vcfg(in_instr);

  // Full/empty come from the occupancy counter, so pointer equality is never ambiguous.
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);

  assign push_acc = q.push && !full && !q.flush;
  assign pop_acc  = q.pop && valid && !q.flush;

`ifdef VIQ_BYPASS_EN
  logic bypass;

  // An empty queue forwards the incoming packet; with a same-cycle pop it never lands in storage.
  assign bypass            = empty && push_acc && q.pop;
  assign valid             = !empty || push_acc;
  assign q.instruction_out = empty ? q.instruction_in : mem[rd_ptr];
  assign q.cfg_pending     = (|flag) || (empty && push_acc && in_cfg);
  assign wr_en             = push_acc && !bypass;
  assign rd_en             = pop_acc && !bypass;
`else
  assign valid             = !empty;
  assign q.instruction_out = mem[rd_ptr];
  assign q.cfg_pending     = |flag;
  assign wr_en             = push_acc;
  assign rd_en             = pop_acc;
`endif

  assign q.ready      = !full;
  assign q.valid_fifo = valid;
  assign q.count      = cnt;

  vector_queue_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (q.flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  vector_queue_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (q.flush),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || q.flush) begin
      cnt <= '0;
    end else if (wr_en && !rd_en) begin
      cnt <= cnt + CW'(1);
    end else if (!wr_en && rd_en) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Flags of free slots are always zero, so OR-ing every flag covers exactly the valid entries.
  always_ff @(posedge clk) begin
    if (!rst_n || q.flush) begin
      flag <= '0;
    end else begin
      if (rd_en) flag[rd_ptr] <= 1'b0;
      if (wr_en) flag[wr_ptr] <= in_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= q.instruction_in;
  end

endmodule
